// File: rtl/blocking_data_cache_if.sv
// Bundles the pipeline MEM-stage port and the line-granular backing-memory
// port of blocking_data_cache.
//   slave  : cache view (serves CPU requests, issues memory requests)
//   master : environment view (pipeline + backing memory)
// Parameter LINE_WORDS must match the cache instance.
interface blocking_data_cache_if #(
   parameter int LINE_WORDS = 4
);
   // CPU side
   logic                     cpu_req_valid;
   logic                     cpu_req_rw;
   logic [31:0]              cpu_req_addr;
   logic [31:0]              cpu_req_wdata;
   logic                     cpu_ready;
   logic                     cpu_resp_valid;
   logic [31:0]              cpu_resp_rdata;
   logic                     cpu_resp_hit;
   // Backing-memory side
   logic                     mem_req_valid;
   logic                     mem_req_rw;
   logic [31:0]              mem_req_addr;
   logic [32*LINE_WORDS-1:0] mem_req_wdata;
   logic                     mem_req_ready;
   logic                     mem_resp_valid;
   logic [32*LINE_WORDS-1:0] mem_resp_rdata;

   modport slave (
      input  cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_wdata,
      output cpu_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit,
      output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata
   );

   modport master (
      output cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_wdata,
      input  cpu_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit,
      input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata
   );
endinterface

// File: rtl/blocking_data_cache.sv
// Direct-mapped, write-back, write-allocate blocking data cache.
// One load/store in flight; one-cycle response pulse; misses write back a
// dirty victim and then fill the whole line from backing memory.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : blocking_data_cache_if.slave (CPU port + memory port)
//   stat_access_cnt / stat_hit_cnt : only when DATA_CACHE_STATS_EN is
//              defined; count responses and hit responses (wrap at 2^32).
// Build option: DATA_CACHE_STATS_EN
module blocking_data_cache #(
   parameter int LINE_WORDS = 4,
   parameter int NUM_SETS   = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   blocking_data_cache_if.slave        bus
`ifdef DATA_CACHE_STATS_EN
   ,
   output logic [31:0]                 stat_access_cnt,
   output logic [31:0]                 stat_hit_cnt
`endif
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = 30 - OFF_W - IDX_W;

   typedef enum logic [2:0] {
      IDLE, COMPARE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT
   } state_e;

   state_e                     state_q, state_d;
   logic                       rw_q;
   logic [31:2]                addr_q;
   logic [31:0]                wdata_q;
   logic                       filled_q;   // current request went through a fill
   logic                       resp_valid_q;
   logic [31:0]                resp_rdata_q;
   logic                       resp_hit_q;

   logic [NUM_SETS-1:0]        valid_q, dirty_q;
   logic [TAG_W-1:0]           tag_q  [NUM_SETS];
   logic [LINE_WORDS-1:0][31:0] data_q [NUM_SETS];

   logic [IDX_W-1:0]           idx;
   logic [OFF_W-1:0]           woff;
   logic [TAG_W-1:0]           tag;
   logic                       hit, accept, hit_done, store_we, wb_done, fill_done;
   logic                       unused_addr_bits;

   // Byte offset is ignored: word accesses only.
   assign unused_addr_bits = ^bus.cpu_req_addr[1:0];

   assign idx  = addr_q[2+OFF_W +: IDX_W];
   assign woff = addr_q[2 +: OFF_W];
   assign tag  = addr_q[31 -: TAG_W];
   assign hit  = valid_q[idx] && (tag_q[idx] == tag);

   assign accept    = (state_q == IDLE) && bus.cpu_req_valid;
   assign hit_done  = (state_q == COMPARE) && hit;
   assign store_we  = hit_done && rw_q;
   assign wb_done   = (state_q == WB_WAIT) && bus.mem_resp_valid;
   assign fill_done = (state_q == FILL_WAIT) && bus.mem_resp_valid;

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (bus.cpu_req_valid) state_d = COMPARE;
         COMPARE: begin
            if (hit)                                 state_d = IDLE;
            else if (valid_q[idx] && dirty_q[idx])   state_d = WB_REQ;
            else                                     state_d = FILL_REQ;
         end
         WB_REQ:    if (bus.mem_req_ready)  state_d = WB_WAIT;
         WB_WAIT:   if (bus.mem_resp_valid) state_d = FILL_REQ;
         FILL_REQ:  if (bus.mem_req_ready)  state_d = FILL_WAIT;
         FILL_WAIT: if (bus.mem_resp_valid) state_d = COMPARE;
         default:   state_d = IDLE;
      endcase
   end

   // Memory request outputs: decoded from state so they stay stable until
   // accepted and read as zero whenever no request is pending.
   always_comb begin
      bus.mem_req_valid = 1'b0;
      bus.mem_req_rw    = 1'b0;
      bus.mem_req_addr  = '0;
      bus.mem_req_wdata = '0;
      case (state_q)
         WB_REQ: begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_rw    = 1'b1;
            bus.mem_req_addr  = {tag_q[idx], idx, {(OFF_W+2){1'b0}}};
            bus.mem_req_wdata = data_q[idx];
         end
         FILL_REQ: begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_addr  = {tag, idx, {(OFF_W+2){1'b0}}};
         end
         default: ;
      endcase
   end

   assign bus.cpu_ready      = (state_q == IDLE);
   assign bus.cpu_resp_valid = resp_valid_q;
   assign bus.cpu_resp_rdata = resp_rdata_q;
   assign bus.cpu_resp_hit   = resp_hit_q;

   // Control and response registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         rw_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         filled_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_hit_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= hit_done;
         resp_rdata_q <= (hit_done && !rw_q) ? data_q[idx][woff] : 32'h0;
         resp_hit_q   <= hit_done && !filled_q;
         if (accept) begin
            rw_q     <= bus.cpu_req_rw;
            addr_q   <= bus.cpu_req_addr[31:2];
            wdata_q  <= bus.cpu_req_wdata;
            filled_q <= 1'b0;
         end
         if (fill_done) filled_q <= 1'b1;
      end
   end

   // Line state bits: the only array state that needs reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (wb_done) dirty_q[idx] <= 1'b0;
         if (fill_done) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end
         if (store_we) dirty_q[idx] <= 1'b1;
      end
   end

   // Tag and data storage; contents are meaningless until valid is set
   always_ff @(posedge clk) begin
      if (fill_done) begin
         data_q[idx] <= bus.mem_resp_rdata;
         tag_q[idx]  <= tag;
      end else if (store_we) begin
         data_q[idx][woff] <= wdata_q;
      end
   end

`ifdef DATA_CACHE_STATS_EN
   logic [31:0] stat_access_q, stat_hit_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_access_q <= '0;
         stat_hit_q    <= '0;
      end else if (resp_valid_q) begin
         stat_access_q <= stat_access_q + 32'd1;
         if (resp_hit_q) stat_hit_q <= stat_hit_q + 32'd1;
      end
   end

   assign stat_access_cnt = stat_access_q;
   assign stat_hit_cnt    = stat_hit_q;
`endif
endmodule

// File: tb/tb_blocking_data_cache.sv
// Directed self-checking bench for blocking_data_cache (4 words/line, 16 sets).
// Index = addr[7:4], so 0x100/0x200/0x300/0x400/0x500 all collide in set 0.
// The memory side is driven by tasks; fill data follows pat(addr).
module tb_blocking_data_cache;
   localparam int LW = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   resp_cnt = 0;

   blocking_data_cache_if #(.LINE_WORDS(LW)) bus ();

`ifdef DATA_CACHE_STATS_EN
   logic [31:0] stat_access_cnt, stat_hit_cnt;
`endif

   blocking_data_cache #(.LINE_WORDS(LW), .NUM_SETS(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef DATA_CACHE_STATS_EN
      ,
      .stat_access_cnt (stat_access_cnt),
      .stat_hit_cnt    (stat_hit_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.cpu_resp_valid) resp_cnt <= resp_cnt + 1;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [127:0] line_pat(input logic [31:0] base);
      logic [127:0] l;
      for (int w = 0; w < LW; w++) l[w*32 +: 32] = pat(base + 32'(w*4));
      return l;
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present a request on a negedge while the cache is idle; accepted at the next posedge.
   task automatic cpu_issue(input logic rw, input logic [31:0] addr, input logic [31:0] wd);
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_rw    = rw;
      bus.cpu_req_addr  = addr;
      bus.cpu_req_wdata = wd;
      @(posedge clk);
      #1 bus.cpu_req_valid = 1'b0;
   endtask

   // n = number of negedges after the accepting edge until the response is seen.
   task automatic wait_resp(output logic [31:0] rd, output logic h, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.cpu_resp_valid && n < 60);
      if (!bus.cpu_resp_valid) chk("resp_timeout", 0, 1);
      rd = bus.cpu_resp_rdata;
      h  = bus.cpu_resp_hit;
   endtask

   // Wait for a memory request, check it, optionally stall it, then accept it.
   task automatic mem_accept(input string tag, input logic rw, input logic [31:0] addr,
                             input int stall, output logic [127:0] wd);
      int n = 0;
      logic [127:0] wd0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.mem_req_valid && n < 60);
      chk({tag, "_req_valid"}, bus.mem_req_valid, 1);
      chk({tag, "_req_rw"}, bus.mem_req_rw, rw);
      chk({tag, "_req_addr"}, bus.mem_req_addr, addr);
      wd0 = bus.mem_req_wdata;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({tag, "_stall_valid"}, bus.mem_req_valid, 1);
         chk({tag, "_stall_addr"}, bus.mem_req_addr, addr);
         chk({tag, "_stall_wdata"}, bus.mem_req_wdata, wd0);
         chk({tag, "_stall_ready"}, bus.cpu_ready, 0);
         chk({tag, "_stall_resp"}, bus.cpu_resp_valid, 0);
      end
      wd = wd0;
      bus.mem_req_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      chk({tag, "_req_dropped"}, bus.mem_req_valid, 0);
   endtask

   task automatic mem_respond(input logic [127:0] line);
      @(negedge clk);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = line;
      @(posedge clk);
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = '0;
   endtask

   initial begin
      logic [31:0]  rd;
      logic         h;
      int           n, c0;
      logic [127:0] wd;

      bus.cpu_req_valid  = 1'b0;
      bus.cpu_req_rw     = 1'b0;
      bus.cpu_req_addr   = '0;
      bus.cpu_req_wdata  = '0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = '0;

      repeat (3) @(negedge clk);
      chk("rst_ready", bus.cpu_ready, 1);
      chk("rst_resp_valid", bus.cpu_resp_valid, 0);
      chk("rst_mem_valid", bus.mem_req_valid, 0);
      chk("rst_mem_addr", bus.mem_req_addr, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // 1: cold load miss, then a hit in the same line
      cpu_issue(0, 32'h100, 0);
      mem_accept("t1_fill", 0, 32'h100, 0, wd);
      mem_respond(line_pat(32'h100));
      wait_resp(rd, h, n);
      chk("t1_miss_data", rd, pat(32'h100));
      chk("t1_miss_hit", h, 0);
      @(negedge clk);
      cpu_issue(0, 32'h104, 0);
      wait_resp(rd, h, n);
      chk("t1_hit_lat", n, 2);
      chk("t1_hit_data", rd, pat(32'h104));
      chk("t1_hit_flag", h, 1);
      chk("t1_ready_with_resp", bus.cpu_ready, 1);

      // 2: store hit, then a conflicting load forces write-back of the dirty line
      @(negedge clk);
      cpu_issue(1, 32'h100, 32'hDEADBEEF);
      wait_resp(rd, h, n);
      chk("t2_st_hit", h, 1);
      chk("t2_st_rdata", rd, 0);
      @(negedge clk);
      cpu_issue(0, 32'h200, 0);
      mem_accept("t2_wb", 1, 32'h100, 0, wd);
      chk("t2_wb_line", wd, {pat(32'h10C), pat(32'h108), pat(32'h104), 32'hDEADBEEF});
      mem_respond('0);
      mem_accept("t2_fill", 0, 32'h200, 0, wd);
      mem_respond(line_pat(32'h200));
      wait_resp(rd, h, n);
      chk("t2_data", rd, pat(32'h200));
      chk("t2_hit", h, 0);

      // 3: dirty 0x200 via store miss-free hit, then stalled write-back
      @(negedge clk);
      cpu_issue(1, 32'h208, 32'h11223344);
      wait_resp(rd, h, n);
      chk("t3_st_hit", h, 1);
      @(negedge clk);
      cpu_issue(0, 32'h300, 0);
      mem_accept("t3_wb", 1, 32'h200, 5, wd);
      chk("t3_wb_line", wd, {pat(32'h20C), 32'h11223344, pat(32'h204), pat(32'h200)});
      mem_respond('0);
      mem_accept("t3_fill", 0, 32'h300, 0, wd);
      mem_respond(line_pat(32'h300));
      wait_resp(rd, h, n);
      chk("t3_data", rd, pat(32'h300));
      chk("t3_hit", h, 0);

      // 5: request valid toggling while busy yields exactly one response
      @(negedge clk);
      c0 = resp_cnt;
      cpu_issue(0, 32'h400, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.cpu_req_valid = ~bus.cpu_req_valid;
         bus.cpu_req_addr  = 32'h40 + 32'(i*16);
         chk("t5_busy_ready", bus.cpu_ready, 0);
      end
      bus.cpu_req_valid = 1'b0;
      mem_accept("t5_fill", 0, 32'h400, 0, wd);
      mem_respond(line_pat(32'h400));
      wait_resp(rd, h, n);
      chk("t5_data", rd, pat(32'h400));
      repeat (5) @(negedge clk);
      chk("t5_resp_count", resp_cnt - c0, 1);

      // 4: reset during FILL_WAIT, late memory response ignored
      cpu_issue(0, 32'h500, 0);
      mem_accept("t4_fill", 0, 32'h500, 0, wd);
      reset_n = 1'b0;
      #1;
      chk("t4_rst_ready", bus.cpu_ready, 1);
      chk("t4_rst_resp", bus.cpu_resp_valid, 0);
      chk("t4_rst_mem_valid", bus.mem_req_valid, 0);
      @(negedge clk);
      reset_n = 1'b1;
      c0 = resp_cnt;
      mem_respond(line_pat(32'h500));
      repeat (3) begin
         @(negedge clk);
         chk("t4_late_ready", bus.cpu_ready, 1);
         chk("t4_late_mem_valid", bus.mem_req_valid, 0);
      end
      chk("t4_late_no_resp", resp_cnt - c0, 0);
`ifdef DATA_CACHE_STATS_EN
      chk("t6_rst_access", stat_access_cnt, 0);
      chk("t6_rst_hit", stat_hit_cnt, 0);
`endif
      // 0x400 was resident before reset; it must miss now
      cpu_issue(0, 32'h400, 0);
      mem_accept("t4_refill", 0, 32'h400, 0, wd);
      mem_respond(line_pat(32'h400));
      wait_resp(rd, h, n);
      chk("t4_refill_hit", h, 0);
      chk("t4_refill_data", rd, pat(32'h400));

      // 6: miss, hit, hit
      @(negedge clk);
      cpu_issue(0, 32'h404, 0);
      wait_resp(rd, h, n);
      chk("t6_hit1", h, 1);
      @(negedge clk);
      cpu_issue(0, 32'h408, 0);
      wait_resp(rd, h, n);
      chk("t6_hit2", h, 1);
      chk("t6_hit2_data", rd, pat(32'h408));
      @(negedge clk);
`ifdef DATA_CACHE_STATS_EN
      chk("t6_access", stat_access_cnt, 3);
      chk("t6_hits", stat_hit_cnt, 2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
